// File: rtl/weights_mem_pkg.sv
// Shared widths, FSM encodings and pending-write bundle
// for the IHP weight-memory write path.
package weights_mem_pkg;

  localparam int WADDR_W = 12;
  localparam int WDATA_W = 16;
  localparam int WCNT_W  = 13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic               hi;
    logic [WDATA_W-1:0] data;
  } wr_ent_t;

endpackage

// File: rtl/weights_loader_ihp_if.sv
// Valid/ready weight stream into the loader.
// master drives weights, slave accepts them.
interface weights_loader_ihp_if;

  logic                                s_valid;
  logic [weights_mem_pkg::WDATA_W-1:0] s_data;
  logic                                s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/weights_wr_skid.sv
// One-entry pending write register: filled on handshake,
// emptied when the write fires (read side idle, no abort).
module weights_wr_skid
  import weights_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr,
  input  logic    fill,
  input  logic    rd_busy,
  input  wr_ent_t din,
  output logic    pend,
  output logic    fire,
  output wr_ent_t dout
);

  logic    pend_q, pend_d;
  wr_ent_t ent_q, ent_d;

  assign fire = pend_q & ~rd_busy & ~clr;
  assign pend = pend_q;
  assign dout = ent_q;

  always_comb begin
    pend_d = pend_q;
    ent_d  = ent_q;
    if (clr) begin
      pend_d = 1'b0;
    end else if (fill) begin
      pend_d = 1'b1;
      ent_d  = din;
    end else if (fire) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      ent_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ent_q  <= ent_d;
    end
  end

endmodule

// File: rtl/weights_loader_ihp.sv
// Packs 16-bit weights into half-word writes of the IHP weight memory.
// Optional running checksum: define WLOAD_CHKSUM_EN.
module weights_loader_ihp
  import weights_mem_pkg::*;
#(
  parameter int ADDR_W = WADDR_W,
  parameter int DATA_W = WDATA_W,
  parameter int CNT_W  = WCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_weights,
  weights_loader_ihp_if.slave s,
  input  logic              rd_busy,
  output logic [ADDR_W-1:0] addra1,
  output logic [DATA_W-1:0] dina1,
  output logic              ena1,
  output logic              wea1,
  output logic [ADDR_W-1:0] addra2,
  output logic [DATA_W-1:0] dina2,
  output logic              ena2,
  output logic              wea2,
  output logic              busy,
  output logic              done,
  output logic              err_wrap,
  output logic [15:0]       chksum
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              half_q, half_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              pend, fire, hs, go;
  wr_ent_t           ent_in, ent_out;

  assign go = ~abort & (state_q == ST_IDLE) & start;

  assign s.s_ready = (state_q == ST_LOAD) & (rem_q != '0)
                   & (~pend | fire) & ~abort;
  assign hs = s.s_valid & s.s_ready;

  assign ent_in = '{addr: addr_q, hi: half_q, data: s.s_data};

  weights_wr_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort),
    .fill    (hs),
    .rd_busy (rd_busy),
    .din     (ent_in),
    .pend    (pend),
    .fire    (fire),
    .dout    (ent_out)
  );

  // wrap_q marks that the word address rolled over; the error
  // is raised only once a weight actually lands past 4095.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    half_d  = half_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          if (start) begin
            state_d = ST_LOAD;
            addr_d  = base_addr;
            rem_d   = num_weights;
            half_d  = 1'b0;
            wrap_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        (state_q == ST_LOAD): begin
          if (hs) begin
            rem_d  = rem_q - 1'b1;
            half_d = ~half_q;
            if (wrap_q) err_d = 1'b1;
            if (half_q) begin
              addr_d = addr_q + 1'b1;
              if (&addr_q) wrap_d = 1'b1;
            end
          end
          if ((rem_q == '0) && !pend) state_d = ST_DONE;
        end
        (state_q == ST_DONE): state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      half_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      half_q  <= half_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign ena1   = fire & ent_out.hi;
  assign ena2   = fire & ~ent_out.hi;
  assign wea1   = ena1;
  assign wea2   = ena2;
  assign addra1 = ent_out.addr;
  assign addra2 = ent_out.addr;
  assign dina1  = ent_out.data;
  assign dina2  = ent_out.data;

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err_wrap = err_q;

`ifdef WLOAD_CHKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (go) sum_d = '0;
    else if (hs) sum_d = sum_q + 16'(s.s_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign chksum = sum_q;
`else
  assign chksum = 16'h0000;
`endif

endmodule

// File: tb/tb_weights_loader_ihp.sv
// Scoreboard bench for weights_loader_ihp.
// Expected writes are queued by stimulus and popped by a monitor.
module tb_weights_loader_ihp;
  import weights_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rd_busy = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] num_weights = '0;
  logic [11:0] addra1, addra2;
  logic [15:0] dina1, dina2, chksum;
  logic        ena1, ena2, wea1, wea2;
  logic        busy, done, err_wrap;

  weights_loader_ihp_if ifc ();

  weights_loader_ihp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .base_addr   (base_addr),
    .num_weights (num_weights),
    .s           (ifc.slave),
    .rd_busy     (rd_busy),
    .addra1      (addra1),
    .dina1       (dina1),
    .ena1        (ena1),
    .wea1        (wea1),
    .addra2      (addra2),
    .dina2       (dina2),
    .ena2        (ena2),
    .wea2        (wea2),
    .busy        (busy),
    .done        (done),
    .err_wrap    (err_wrap),
    .chksum      (chksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [11:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  exp_t mon_e;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ena1 || ena2) begin
      wr_cyc.push_back(cyc);
      chk("dual_port", {63'd0, ena1 & ena2}, 0);
      chk("we_eq_en", {wea1, wea2}, {ena1, ena2});
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {ena1, addra1, dina1}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_port", ena1 ? 1 : 2, mon_e.port);
        chk("wr_addr", ena1 ? addra1 : addra2, mon_e.addr);
        chk("wr_data", ena1 ? dina1 : dina2, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p,
                      input logic [11:0] a,
                      input logic [15:0] d);
    exp_t e;
    e.port = p;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [11:0] b,
                          input logic [12:0] n,
                          output int sc);
    base_addr   = b;
    num_weights = n;
    start       = 1'b1;
    sc          = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    while (!ok && t < 40) begin
      @(negedge clk);
      ok = ifc.s_ready;
      tick();
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n0);
    int t;
    t = 0;
    while (done_cnt == n0 && t < 60) begin
      tick();
      t++;
    end
    chk("done_seen", done_cnt, n0 + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    int sc, n0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    tick();
    chk("rst_ctrl",
        {ifc.s_ready, ena1, ena2, wea1, wea2, busy, done, err_wrap}, 0);
    chk("rst_data", {addra1, addra2, dina1, dina2}, 0);
    chk("rst_sum", chksum, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: back-to-back packing and latency
    wr_cyc.delete();
    n0 = done_cnt;
    push(2, 12'h010, 16'd1);
    push(1, 12'h010, 16'd2);
    push(2, 12'h011, 16'd3);
    push(1, 12'h011, 16'd4);
    do_start(12'h010, 13'd4, sc);
    send(16'd1);
    send(16'd2);
    send(16'd3);
    send(16'd4);
    ifc.s_valid = 1'b0;
    wait_done(n0);
    chk("t1_done_cyc", done_cyc - sc, 7);
    chk("t1_idle", busy, 0);
    chk("t1_wr_count", wr_cyc.size(), 4);
    foreach (wr_cyc[i]) chk("t1_wr_cyc", wr_cyc[i] - sc, i + 2);

    // T2: odd count leaves the last high half untouched
    n0 = done_cnt;
    push(2, 12'h800, 16'h0011);
    push(1, 12'h800, 16'h0022);
    push(2, 12'h801, 16'h0033);
    do_start(12'h800, 13'd3, sc);
    send(16'h0011);
    send(16'h0022);
    send(16'h0033);
    ifc.s_valid = 1'b0;
    wait_done(n0);
    repeat (5) tick();
    chk("t2_done_once", done_cnt, n0 + 1);

    // T3: read side holds the pending write
    n0 = done_cnt;
    push(2, 12'h020, 16'h000A);
    push(1, 12'h020, 16'h000B);
    do_start(12'h020, 13'd2, sc);
    send(16'h000A);
    rd_busy = 1'b1;
    ifc.s_data = 16'h000B;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_en", {ena1, ena2}, 0);
      chk("t3_hold_rdy", ifc.s_ready, 0);
      tick();
    end
    rd_busy = 1'b0;
    @(negedge clk);
    chk("t3_fire", {ena1, ena2}, 2'b01);
    chk("t3_rdy", ifc.s_ready, 1);
    tick();
    ifc.s_valid = 1'b0;
    wait_done(n0);

    // T4: address wrap past 4095
    n0 = done_cnt;
    push(2, 12'hFFF, 16'h0005);
    push(1, 12'hFFF, 16'h0006);
    push(2, 12'h000, 16'h0007);
    push(1, 12'h000, 16'h0008);
    do_start(12'hFFF, 13'd4, sc);
    send(16'h0005);
    send(16'h0006);
    chk("t4_err_pre", err_wrap, 0);
    send(16'h0007);
    chk("t4_err_set", err_wrap, 1);
    send(16'h0008);
    ifc.s_valid = 1'b0;
    wait_done(n0);
    chk("t4_err_sticky", err_wrap, 1);

    // T5: abort drops the pending write
    n0 = done_cnt;
    push(2, 12'h100, 16'h0021);
    do_start(12'h100, 13'd6, sc);
    chk("t5_err_clr", err_wrap, 0);
    send(16'h0021);
    send(16'h0022);
    abort = 1'b1;
    ifc.s_data = 16'h0023;
    @(negedge clk);
    chk("t5_abort_en", {ena1, ena2}, 0);
    chk("t5_abort_rdy", ifc.s_ready, 0);
    tick();
    abort = 1'b0;
    ifc.s_valid = 1'b0;
    chk("t5_busy", busy, 0);
    repeat (8) tick();
    chk("t5_no_done", done_cnt, n0);

    // T6: checksum
    n0 = done_cnt;
    do_start(12'h200, 13'd2, sc);
    chk("t6_sum_clr", chksum, 0);
    push(2, 12'h200, 16'hFFFF);
    push(1, 12'h200, 16'h0002);
    send(16'hFFFF);
    send(16'h0002);
    ifc.s_valid = 1'b0;
`ifdef WLOAD_CHKSUM_EN
    chk("t6_sum", chksum, 16'h0001);
`else
    chk("t6_sum", chksum, 16'h0000);
`endif
    wait_done(n0);

    // T7: zero-length load
    n0 = done_cnt;
    do_start(12'h300, 13'd0, sc);
    wait_done(n0);
    chk("t7_done_cyc", done_cyc - sc, 2);

    // T8: async reset mid-load
    push(2, 12'hFFF, 16'h0031);
    push(1, 12'hFFF, 16'h0032);
    do_start(12'hFFF, 13'd4, sc);
    send(16'h0031);
    send(16'h0032);
    send(16'h0033);
    ifc.s_valid = 1'b0;
    chk("t8_err_pre", err_wrap, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t8_rst_ctrl",
        {ifc.s_ready, ena1, ena2, wea1, wea2, busy, done, err_wrap}, 0);
    chk("t8_rst_data", {addra1, addra2, dina1, dina2}, 0);
    chk("t8_rst_sum", chksum, 0);
    chk("t8_q_empty", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    chk("final_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
